// File: rtl/fw_trigger_sequencer_pkg.sv
// fw_trigger_sequencer_pkg
//   Shared definitions for the firmware trigger sequencer:
//   - trigger register field positions (GO, CMD, LINE, DELAY)
//   - command encodings written by firmware into CMD
//   - sequencer FSM state encoding
//   - helper that turns a line number into a one-hot interrupt mask
package fw_trigger_sequencer_pkg;

  // Trigger register layout
  localparam int FW_TRIG_GO_BIT    = 31;
  localparam int FW_TRIG_CMD_MSB   = 30;
  localparam int FW_TRIG_CMD_LSB   = 29;
  localparam int FW_TRIG_LINE_MSB  = 28;
  localparam int FW_TRIG_LINE_LSB  = 24;
  localparam int FW_TRIG_DELAY_MSB = 23;
  localparam int FW_TRIG_DELAY_LSB = 0;

  // A queued command is everything below GO
  localparam int FW_TRIG_ENTRY_W = FW_TRIG_GO_BIT;

  typedef enum logic [1:0] {
    FW_TRIG_PULSE     = 2'd0,
    FW_TRIG_SET       = 2'd1,
    FW_TRIG_CLR       = 2'd2,
    FW_TRIG_RESET_ALL = 2'd3
  } fw_trig_cmd_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_WAIT = 2'd1,
    SEQ_FIRE = 2'd2
  } seq_state_e;

  // One-hot mask for a single interrupt line
  function automatic logic [31:0] fw_line_mask(input logic [4:0] line);
    fw_line_mask = 32'd1 << line;
  endfunction

endpackage

// File: rtl/fw_trigger_fifo.sv
// fw_trigger_fifo
//   Small synchronous command FIFO for the trigger sequencer.
//   Show-ahead: rd_data always presents the oldest entry so the consumer can
//   latch it on the same edge that pops it.
//   A push while full is accepted only if a pop happens in the same cycle
//   (the pop frees the slot first); otherwise the push is ignored and the
//   caller is responsible for flagging the drop.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset, empties the FIFO
//   push     in   write wr_data
//   pop      in   discard the head entry
//   wr_data  in   WIDTH  entry to write
//   rd_data  out  WIDTH  head entry (valid when !empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   count    out  $clog2(DEPTH)+1  entries held
module fw_trigger_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  logic do_pop;
  logic do_push;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // One register per entry so every slot can be cleared by reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fw_trigger_sequencer.sv
// fw_trigger_sequencer
//   Turns firmware trigger commands into timed interrupt stimulus.
//   A rising edge on GO queues CMD/LINE/DELAY; the sequencer FSM executes
//   queued commands one at a time: wait DELAY cycles, then pulse, set or
//   clear a line, or clear all levels and the overflow flag.
// Ports
//   wb_clk_i     in   1    system clock
//   wb_rst_i     in   1    asynchronous active-high reset
//   trigger_reg  in   32   {GO, CMD[1:0], LINE[4:0], DELAY[23:0]}
//   interrupts   out  32   level_reg | pulse_vec
//   busy         out  1    command executing or queued
//   overflow     out  1    sticky: a command was dropped on a full queue
//   fifo_count   out  $clog2(FIFO_DEPTH)+1  queued commands
module fw_trigger_sequencer
  import fw_trigger_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PULSE_CYCLES = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [31:0]                   trigger_reg,
  output logic [31:0]                   interrupts,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);

  // Edge detect on GO
  logic trig_go_q_reg;
  logic go_edge;

  // Queue interface
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FW_TRIG_ENTRY_W-1:0] fifo_rd_data;
  fw_trig_cmd_e               head_cmd;
  logic [4:0]                 head_line;
  logic [23:0]                head_delay;
  logic                       cmd_drop;

  // Sequencer state
  seq_state_e         state_reg;
  fw_trig_cmd_e       cmd_reg;
  logic [4:0]         line_reg;
  logic [23:0]        cnt_reg;
  logic [PULSE_W-1:0] pulse_cnt_reg;
  logic [31:0]        level_reg;
  logic [31:0]        pulse_vec_reg;
  logic               overflow_reg;
  logic               fire_now;
  logic               reset_all_fire;

  assign go_edge   = trigger_reg[FW_TRIG_GO_BIT] & ~trig_go_q_reg;
  assign fifo_push = go_edge;
  assign fifo_pop  = (state_reg == SEQ_IDLE) & ~fifo_empty;
  // Mirrors the FIFO's own accept rule: a full queue only takes a push
  // when the sequencer pops in the same cycle.
  assign cmd_drop  = go_edge & fifo_full & ~fifo_pop;

  assign head_cmd   = fw_trig_cmd_e'(fifo_rd_data[FW_TRIG_CMD_MSB:FW_TRIG_CMD_LSB]);
  assign head_line  = fifo_rd_data[FW_TRIG_LINE_MSB:FW_TRIG_LINE_LSB];
  assign head_delay = fifo_rd_data[FW_TRIG_DELAY_MSB:FW_TRIG_DELAY_LSB];

  // The action is applied on the WAIT->FIRE edge so it is visible
  // DELAY+2 edges after the GO edge.
  assign fire_now       = (state_reg == SEQ_WAIT) && (cnt_reg == '0);
  assign reset_all_fire = fire_now && (cmd_reg == FW_TRIG_RESET_ALL);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      trig_go_q_reg <= 1'b0;
    end else begin
      trig_go_q_reg <= trigger_reg[FW_TRIG_GO_BIT];
    end
  end

  fw_trigger_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW_TRIG_ENTRY_W)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (trigger_reg[FW_TRIG_CMD_MSB:FW_TRIG_DELAY_LSB]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sequencer FSM: IDLE -> WAIT -> FIRE -> IDLE
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= SEQ_IDLE;
      cmd_reg       <= FW_TRIG_PULSE;
      line_reg      <= '0;
      cnt_reg       <= '0;
      pulse_cnt_reg <= '0;
      level_reg     <= '0;
      pulse_vec_reg <= '0;
    end else begin
      case (state_reg)
        SEQ_IDLE: begin
          if (fifo_pop) begin
            cmd_reg   <= head_cmd;
            line_reg  <= head_line;
            cnt_reg   <= head_delay;
            state_reg <= SEQ_WAIT;
          end
        end

        SEQ_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= SEQ_FIRE;
            case (cmd_reg)
              FW_TRIG_PULSE: begin
                pulse_vec_reg <= fw_line_mask(line_reg);
                // Line is already high for this cycle; count the rest.
                pulse_cnt_reg <= PULSE_W'(PULSE_CYCLES - 1);
              end
              FW_TRIG_SET:       level_reg[line_reg] <= 1'b1;
              FW_TRIG_CLR:       level_reg[line_reg] <= 1'b0;
              FW_TRIG_RESET_ALL: level_reg <= '0;
              default:           level_reg <= level_reg;
            endcase
          end else begin
            cnt_reg <= cnt_reg - 24'd1;
          end
        end

        SEQ_FIRE: begin
          if ((cmd_reg == FW_TRIG_PULSE) && (pulse_cnt_reg != '0)) begin
            pulse_cnt_reg <= pulse_cnt_reg - PULSE_W'(1);
          end else begin
            pulse_vec_reg <= '0;
            state_reg     <= SEQ_IDLE;
          end
        end

        default: begin
          pulse_vec_reg <= '0;
          state_reg     <= SEQ_IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as RESET_ALL fires is newer, so it wins.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      overflow_reg <= 1'b0;
    end else if (cmd_drop) begin
      overflow_reg <= 1'b1;
    end else if (reset_all_fire) begin
      overflow_reg <= 1'b0;
    end
  end

  assign interrupts = level_reg | pulse_vec_reg;
  assign busy       = (state_reg != SEQ_IDLE) | ~fifo_empty;
  assign overflow   = overflow_reg;

endmodule
